uart_rx_tx: RTL and testbench

Full-duplex UART endpoint carrying fixed-width words rather than bytes: a transmitter serializes 32-bit words and a receiver deserializes 34-bit words. Each frame is 1 start bit, N data bits sent LSB first, and 1 stop bit, at a baud rate set by a clocks-per-bit parameter. The block sits between the serial pins and the core-side logic that produces and consumes these words.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_core.sv | 112 +++++++++++
 rtl/uart_tx_core.sv | 109 ++++++++++
 rtl/uart_rx_tx.sv | 46 ++++
 tb/tb_uart_rx_tx.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the word-oriented UART endpoint.
// Both the receiver and the transmitter use the state type below.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_CLEANUP = 3'd4
   } uart_state_e;

   localparam int UART_CLKS_PER_BIT = 434;
   localparam int UART_RX_WIDTH     = 34;
   localparam int UART_TX_WIDTH     = 32;

endpackage

// File: rtl/uart_rx_core.sv
// Receiver: synchronizes the serial line, finds the start bit and samples
// each data bit at its centre, LSB first.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int WIDTH        = UART_RX_WIDTH
) (
   input  logic             i_Clock,
   input  logic             i_Rst_n,
   input  logic             i_Rx_Serial,
   output logic             o_Rx_DV,
   output logic [WIDTH-1:0] o_Rx_Byte
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   logic [1:0]       sync_r;
   logic             rx_s;
   uart_state_e      state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [IDX_W-1:0] idx_r;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] byte_r;
   logic             dv_r;

   // Two-flop synchronizer, preset to the idle-high line level
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], i_Rx_Serial};
      end
   end

   assign rx_s = sync_r[1];

   // Receive sequencer; bits shift in from the top so bit 0 lands at the LSB
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         idx_r   <= '0;
         shift_r <= '0;
         byte_r  <= '0;
         dv_r    <= 1'b0;
      end else begin
         dv_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               cnt_r <= '0;
               idx_r <= '0;
               if (!rx_s) begin
                  state_r <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_r == CNT_HALF) begin
                  cnt_r <= '0;
                  if (!rx_s) begin
                     state_r <= ST_DATA;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_r < CNT_LAST) begin
                  cnt_r <= cnt_r + 1'b1;
               end else begin
                  cnt_r   <= '0;
                  shift_r <= {rx_s, shift_r[WIDTH-1:1]};
                  if (idx_r < IDX_LAST) begin
                     idx_r <= idx_r + 1'b1;
                  end else begin
                     idx_r   <= '0;
                     state_r <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (cnt_r < CNT_LAST) begin
                  cnt_r <= cnt_r + 1'b1;
               end else begin
                  cnt_r   <= '0;
                  byte_r  <= shift_r;
                  dv_r    <= 1'b1;
                  state_r <= ST_CLEANUP;
               end
            end
            ST_CLEANUP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
               idx_r   <= '0;
            end
         endcase
      end
   end

   assign o_Rx_DV   = dv_r;
   assign o_Rx_Byte = byte_r;

endmodule

// File: rtl/uart_tx_core.sv
// Transmitter: latches a word on request and sends start, data (LSB first)
// and stop bits, each held for CLKS_PER_BIT clocks.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int WIDTH        = UART_TX_WIDTH
) (
   input  logic             i_Clock,
   input  logic             i_Rst_n,
   input  logic             i_Tx_DV,
   input  logic [WIDTH-1:0] i_Tx_Byte,
   output logic             o_Tx_Active,
   output logic             o_Tx_Serial,
   output logic             o_Tx_Done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   uart_state_e      state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [IDX_W-1:0] idx_r;
   logic [WIDTH-1:0] data_r;
   logic             serial_r;
   logic             active_r;
   logic             done_r;

   // Transmit sequencer; the latched word shifts right as each bit completes
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= '0;
         idx_r    <= '0;
         data_r   <= '0;
         serial_r <= 1'b1;
         active_r <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               serial_r <= 1'b1;
               cnt_r    <= '0;
               idx_r    <= '0;
               if (i_Tx_DV) begin
                  data_r   <= i_Tx_Byte;
                  active_r <= 1'b1;
                  state_r  <= ST_START;
               end else begin
                  active_r <= 1'b0;
               end
            end
            ST_START: begin
               serial_r <= 1'b0;
               if (cnt_r < CNT_LAST) begin
                  cnt_r <= cnt_r + 1'b1;
               end else begin
                  cnt_r   <= '0;
                  state_r <= ST_DATA;
               end
            end
            ST_DATA: begin
               serial_r <= data_r[0];
               if (cnt_r < CNT_LAST) begin
                  cnt_r <= cnt_r + 1'b1;
               end else begin
                  cnt_r  <= '0;
                  data_r <= {1'b0, data_r[WIDTH-1:1]};
                  if (idx_r < IDX_LAST) begin
                     idx_r <= idx_r + 1'b1;
                  end else begin
                     idx_r   <= '0;
                     state_r <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               serial_r <= 1'b1;
               if (cnt_r < CNT_LAST) begin
                  cnt_r <= cnt_r + 1'b1;
               end else begin
                  cnt_r    <= '0;
                  done_r   <= 1'b1;
                  active_r <= 1'b0;
                  state_r  <= ST_CLEANUP;
               end
            end
            ST_CLEANUP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               serial_r <= 1'b1;
               active_r <= 1'b0;
               cnt_r    <= '0;
               idx_r    <= '0;
            end
         endcase
      end
   end

   assign o_Tx_Active = active_r;
   assign o_Tx_Serial = serial_r;
   assign o_Tx_Done   = done_r;

endmodule

// File: rtl/uart_rx_tx.sv
// Full-duplex word UART: independent receiver and transmitter sharing
// one clock and reset.
module uart_rx_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int RX_WIDTH     = UART_RX_WIDTH,
   parameter int TX_WIDTH     = UART_TX_WIDTH
) (
   input  logic                i_Clock,
   input  logic                i_Rst_n,
   input  logic                i_Rx_Serial,
   output logic                o_Rx_DV,
   output logic [RX_WIDTH-1:0] o_Rx_Byte,
   input  logic                i_Tx_DV,
   input  logic [TX_WIDTH-1:0] i_Tx_Byte,
   output logic                o_Tx_Active,
   output logic                o_Tx_Serial,
   output logic                o_Tx_Done
);

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .WIDTH        (RX_WIDTH)
   ) u_rx (
      .i_Clock      (i_Clock),
      .i_Rst_n      (i_Rst_n),
      .i_Rx_Serial  (i_Rx_Serial),
      .o_Rx_DV      (o_Rx_DV),
      .o_Rx_Byte    (o_Rx_Byte)
   );

   uart_tx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .WIDTH        (TX_WIDTH)
   ) u_tx (
      .i_Clock      (i_Clock),
      .i_Rst_n      (i_Rst_n),
      .i_Tx_DV      (i_Tx_DV),
      .i_Tx_Byte    (i_Tx_Byte),
      .o_Tx_Active  (o_Tx_Active),
      .o_Tx_Serial  (o_Tx_Serial),
      .o_Tx_Done    (o_Tx_Done)
   );

endmodule

// File: tb/tb_uart_rx_tx.sv
// Scoreboard bench for uart_rx_tx: stimulus pushes expected words, separate
// monitors decode the TX line and the RX valid pulses and compare.
module tb_uart_rx_tx;

   localparam int CPB   = 434;
   localparam int RXW   = 34;
   localparam int TXW   = 32;
   localparam int FRAME = (TXW + 2) * CPB;

   logic            i_Clock     = 1'b0;
   logic            i_Rst_n     = 1'b0;
   logic            i_Rx_Serial = 1'b1;
   logic            i_Tx_DV     = 1'b0;
   logic [TXW-1:0]  i_Tx_Byte   = '0;
   logic            o_Rx_DV;
   logic [RXW-1:0]  o_Rx_Byte;
   logic            o_Tx_Active;
   logic            o_Tx_Serial;
   logic            o_Tx_Done;

   int n_vec    = 0;
   int n_err    = 0;
   int done_cnt = 0;
   int dv_cnt   = 0;

   logic [TXW-1:0] tx_exp_q[$];
   logic [RXW-1:0] rx_exp_q[$];

   uart_rx_tx #(
      .CLKS_PER_BIT (CPB),
      .RX_WIDTH     (RXW),
      .TX_WIDTH     (TXW)
   ) dut (
      .i_Clock      (i_Clock),
      .i_Rst_n      (i_Rst_n),
      .i_Rx_Serial  (i_Rx_Serial),
      .o_Rx_DV      (o_Rx_DV),
      .o_Rx_Byte    (o_Rx_Byte),
      .i_Tx_DV      (i_Tx_DV),
      .i_Tx_Byte    (i_Tx_Byte),
      .o_Tx_Active  (o_Tx_Active),
      .o_Tx_Serial  (o_Tx_Serial),
      .o_Tx_Done    (o_Tx_Done)
   );

   // 50 MHz system clock
   always #10ns i_Clock = ~i_Clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_tx(input logic [TXW-1:0] w, input bit push);
      @(negedge i_Clock);
      i_Tx_Byte = w;
      i_Tx_DV   = 1'b1;
      if (push) tx_exp_q.push_back(w);
      @(negedge i_Clock);
      i_Tx_DV = 1'b0;
   endtask

   // Drives start bit, nbits data bits (LSB first) and, for a full word, the stop bit
   task automatic drive_rx(input logic [RXW-1:0] w, input int start_ns, input int bit_ns,
                           input int nbits, input bit push);
      if (push) rx_exp_q.push_back(w);
      i_Rx_Serial = 1'b0;
      #(start_ns * 1ns);
      for (int i = 0; i < nbits; i++) begin
         i_Rx_Serial = w[i];
         #(bit_ns * 1ns);
      end
      if (nbits == RXW) begin
         i_Rx_Serial = 1'b1;
         #(bit_ns * 1ns);
      end
   endtask

   task automatic wait_drained(input int max_cyc, input string name);
      int k;
      k = 0;
      while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0) && k < max_cyc) begin
         @(negedge i_Clock);
         k++;
      end
      n_vec++;
      if (k >= max_cyc) begin
         n_err++;
         $display("FAIL %s_timeout: %0d tx and %0d rx words still pending after %0d cycles, required 0",
                  name, tx_exp_q.size(), rx_exp_q.size(), k);
      end
   endtask

   // Pulse counting and receive-side scoreboard
   initial begin : rx_mon
      forever begin
         @(negedge i_Clock);
         if (o_Tx_Done) done_cnt++;
         if (o_Rx_DV) begin
            dv_cnt++;
            if (rx_exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rx_unexpected: got pulse with word %h, required no pulse", o_Rx_Byte);
            end else begin
               check("rx_word", 64'(o_Rx_Byte), 64'(rx_exp_q.pop_front()));
            end
         end
      end
   end

   // Transmit-side scoreboard: decodes each frame from the serial line
   initial begin : tx_mon
      logic [RXW-1:0] first_v;
      logic [RXW-1:0] last_v;
      logic [TXW-1:0] w;
      bit             act_ok;
      bit             aborted;
      int             done_at;
      int             done_hits;
      forever begin
         @(negedge i_Clock);
         if (i_Rst_n && !o_Tx_Serial) begin
            first_v = '0; last_v = '0; act_ok = 1'b1; aborted = 1'b0;
            done_at = -1; done_hits = 0;
            for (int c = 0; c <= FRAME + 1; c++) begin
               if (c > 0) @(negedge i_Clock);
               if (!i_Rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (c < FRAME) begin
                  if (c % CPB == 0)       first_v[c / CPB] = o_Tx_Serial;
                  if (c % CPB == CPB - 1) last_v[c / CPB]  = o_Tx_Serial;
               end
               if (c < FRAME - 1 && !o_Tx_Active) act_ok = 1'b0;
               if (o_Tx_Done) begin
                  done_hits++;
                  if (done_at < 0) done_at = c;
               end
            end
            if (!aborted) begin
               if (tx_exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL tx_unexpected: got frame %h, required no frame", first_v);
               end else begin
                  w = tx_exp_q.pop_front();
                  check("tx_frame_bit_start", 64'(first_v), 64'({1'b1, w, 1'b0}));
                  check("tx_frame_bit_end",   64'(last_v),  64'({1'b1, w, 1'b0}));
                  check("tx_done_offset",     64'(done_at), 64'(FRAME - 1));
                  check("tx_done_pulses",     64'(done_hits), 64'd1);
                  check("tx_active_frame",    64'(act_ok),  64'd1);
               end
            end
         end
      end
   end

   initial begin : stim
      // Reset with random inputs
      for (int i = 0; i < 8; i++) begin
         @(negedge i_Clock);
         i_Rx_Serial = 1'($urandom);
         i_Tx_DV     = 1'($urandom);
         i_Tx_Byte   = $urandom;
      end
      check("reset_outputs", 64'({o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Rx_DV}), 64'(4'b1000));
      check("reset_rx_byte", 64'(o_Rx_Byte), 64'd0);
      i_Rx_Serial = 1'b1;
      i_Tx_DV     = 1'b0;
      @(negedge i_Clock);
      i_Rst_n = 1'b1;
      repeat (5) @(negedge i_Clock);

      // Simultaneous TX word and RX word with long start bit and fast bits
      fork
         send_tx(32'h0DB4_F255, 1'b1);
         drive_rx(34'h2_9694_E962, 9600, 8600, RXW, 1'b1);
      join
      wait_drained(20000, "basic");

      // TX busy request ignored; RX glitch then a minimal valid word
      fork
         begin
            send_tx(32'hA5C3_0F96, 1'b1);
            repeat (5000) @(negedge i_Clock);
            send_tx(32'hFFFF_FFFF, 1'b0);
         end
         begin
            i_Rx_Serial = 1'b0;
            repeat (100) @(negedge i_Clock);
            i_Rx_Serial = 1'b1;
            repeat (300) @(negedge i_Clock);
            drive_rx(34'h0_0000_0001, 8680, 8680, RXW, 1'b1);
         end
      join
      wait_drained(20000, "busy_glitch");

      // Reset asserted halfway through both frames
      fork
         send_tx(32'h1234_5678, 1'b0);
         drive_rx(34'h1_5555_AAAA, 8680, 8680, 16, 1'b0);
      join
      @(negedge i_Clock);
      i_Rst_n     = 1'b0;
      i_Rx_Serial = 1'b1;
      @(negedge i_Clock);
      check("midreset_outputs", 64'({o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Rx_DV}), 64'(4'b1000));
      check("midreset_rx_byte", 64'(o_Rx_Byte), 64'd0);
      repeat (3) @(negedge i_Clock);
      i_Rst_n = 1'b1;
      repeat (20) @(negedge i_Clock);

      // Frames after the aborted ones complete normally
      fork
         send_tx(32'h8000_0001, 1'b1);
         drive_rx(34'h3_C0FF_EE01, 8680, 8680, RXW, 1'b1);
      join
      wait_drained(20000, "post_reset");
      repeat (50) @(negedge i_Clock);

      check("rx_byte_held", 64'(o_Rx_Byte), 64'(34'h3_C0FF_EE01));
      check("tx_done_total", 64'(done_cnt), 64'd3);
      check("rx_dv_total", 64'(dv_cnt), 64'd3);
      check("final_outputs", 64'({o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Rx_DV}), 64'(4'b1000));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time limit so the run always terminates
   initial begin : watchdog
      #(2000000 * 1ns);
      n_err++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "time limit");
   end

endmodule
